// File: rtl/pipelined_multiplier_pkg.sv
// Shared op encoding and operand/result decode helpers for the MUL/DIV lane.
// Encodings follow the RISC-V funct3 values of the M-extension multiplies.
package MulDivTypes;

  typedef enum logic [1:0] {
    MUL    = 2'b00,
    MULH   = 2'b01,
    MULHSU = 2'b10,
    MULHU  = 2'b11
  } MulCode;

  function automatic logic mulOp1Signed(input MulCode op);
    return op != MULHU;
  endfunction

  function automatic logic mulOp2Signed(input MulCode op);
    return (op == MUL) || (op == MULH);
  endfunction

  function automatic logic mulSelectHigh(input MulCode op);
    return op != MUL;
  endfunction

endpackage

// File: rtl/pipelined_multiplier_sign_extender.sv
// Widens one multiplier operand by a single bit so that signed and unsigned
// operands can share one signed (WIDTH+1)x(WIDTH+1) multiplier.
module operand_sign_extender #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] operand,
  input  logic             is_signed,
  output logic [WIDTH:0]   extended
);

  assign extended = {is_signed & operand[WIDTH-1], operand};

endmodule

// File: rtl/pipelined_multiplier.sv
// Fully pipelined M-extension multiplier: registered operands, one signed multiply,
// then STAGES-1 product slices, all moving together under a single global stall.
module pipelined_multiplier
  import MulDivTypes::*;
#(
  parameter int WIDTH     = 32,
  parameter int STAGES    = 3,
  parameter int TAG_WIDTH = 6
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  MulCode               in_op,
  input  logic [WIDTH-1:0]     in_op1,
  input  logic [WIDTH-1:0]     in_op2,
  input  logic [TAG_WIDTH-1:0] in_tag,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WIDTH-1:0]     out_result,
  output logic [TAG_WIDTH-1:0] out_tag
);

  localparam int EXT_WIDTH  = WIDTH + 1;
  localparam int PROD_WIDTH = 2 * WIDTH + 2;
  localparam int SLICES     = (STAGES > 1) ? STAGES - 1 : 1;

  typedef struct packed {
    logic                 valid;
    logic                 sel_high;
    logic [TAG_WIDTH-1:0] tag;
    logic [EXT_WIDTH-1:0] op1;
    logic [EXT_WIDTH-1:0] op2;
  } operand_stage_t;

  typedef struct packed {
    logic                  valid;
    logic                  sel_high;
    logic [TAG_WIDTH-1:0]  tag;
    logic [PROD_WIDTH-1:0] product;
  } product_stage_t;

  logic                  advance;
  logic                  in_fire;
  logic [EXT_WIDTH-1:0]  ext_op1;
  logic [EXT_WIDTH-1:0]  ext_op2;
  logic                  feed_valid;
  logic                  feed_sel_high;
  logic [TAG_WIDTH-1:0]  feed_tag;
  logic [EXT_WIDTH-1:0]  mul_a;
  logic [EXT_WIDTH-1:0]  mul_b;
  logic [PROD_WIDTH-1:0] mul_product;
  product_stage_t        mul_feed;
  product_stage_t        slice [SLICES];
  product_stage_t        out_stage;
  logic                  unused_product_msbs;

  // Only a stalled, occupied output slice can hold the pipe, so out_ready reaches in_ready combinationally.
  assign advance  = !(out_valid && !out_ready);
  assign in_ready = advance;
  assign in_fire  = in_valid && advance;

  operand_sign_extender #(.WIDTH(WIDTH)) u_ext_op1 (
    .operand   (in_op1),
    .is_signed (mulOp1Signed(in_op)),
    .extended  (ext_op1)
  );

  operand_sign_extender #(.WIDTH(WIDTH)) u_ext_op2 (
    .operand   (in_op2),
    .is_signed (mulOp2Signed(in_op)),
    .extended  (ext_op2)
  );

  if (STAGES > 1) begin : g_operand_stage
    operand_stage_t op_stage;

    always_ff @(posedge clk) begin
      if (rst) begin
        op_stage <= '0;
      end else begin
        if (flush) begin
          op_stage.valid <= 1'b0;
        end else if (advance) begin
          op_stage.valid <= in_fire;
        end
        if (advance) begin
          op_stage.sel_high <= mulSelectHigh(in_op);
          op_stage.tag      <= in_tag;
          op_stage.op1      <= ext_op1;
          op_stage.op2      <= ext_op2;
        end
      end
    end

    assign feed_valid    = op_stage.valid;
    assign feed_sel_high = op_stage.sel_high;
    assign feed_tag      = op_stage.tag;
    assign mul_a         = op_stage.op1;
    assign mul_b         = op_stage.op2;
  end else begin : g_direct_feed
    assign feed_valid    = in_fire;
    assign feed_sel_high = mulSelectHigh(in_op);
    assign feed_tag      = in_tag;
    assign mul_a         = ext_op1;
    assign mul_b         = ext_op2;
  end

  // Operands are widened to the full product width so the multiply is exactly signed and lint-width clean.
  assign mul_product = $signed({{EXT_WIDTH{mul_a[WIDTH]}}, mul_a}) *
                       $signed({{EXT_WIDTH{mul_b[WIDTH]}}, mul_b});

  assign mul_feed = '{valid:    feed_valid,
                      sel_high: feed_sel_high,
                      tag:      feed_tag,
                      product:  mul_product};

  for (genvar s = 0; s < SLICES; s++) begin : g_slice
    product_stage_t src;

    if (s == 0) begin : g_first
      assign src = mul_feed;
    end else begin : g_next
      assign src = slice[s-1];
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        slice[s] <= '0;
      end else begin
        if (flush) begin
          slice[s].valid <= 1'b0;
        end else if (advance) begin
          slice[s].valid <= src.valid;
        end
        if (advance) begin
          slice[s].sel_high <= src.sel_high;
          slice[s].tag      <= src.tag;
          slice[s].product  <= src.product;
        end
      end
    end
  end

  assign out_stage  = slice[SLICES-1];
  assign out_valid  = out_stage.valid;
  assign out_tag    = out_stage.tag;
  assign out_result = out_stage.sel_high ? out_stage.product[2*WIDTH-1:WIDTH]
                                         : out_stage.product[WIDTH-1:0];

  // The two product MSBs only exist to keep the signed multiply exact.
  assign unused_product_msbs = ^out_stage.product[PROD_WIDTH-1:2*WIDTH];

endmodule

// File: tb/tb_pipelined_multiplier.sv
// Randomised and directed checks of pipelined_multiplier against an integer-arithmetic
// reference model; a 32/3 instance carries the directed tests, 8/1 and 64/6 the sweep.
module tb_pipelined_multiplier;
  import MulDivTypes::*;

  localparam int W  = 32;
  localparam int S  = 3;
  localparam int TW = 6;

  typedef struct {
    logic [63:0]   res;
    logic [TW-1:0] tag;
  } exp_t;

  logic          clk;
  logic          rst;
  logic          flush;
  logic          in_valid;
  logic          in_ready;
  MulCode        in_op;
  logic [W-1:0]  in_op1;
  logic [W-1:0]  in_op2;
  logic [TW-1:0] in_tag;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  out_result;
  logic [TW-1:0] out_tag;

  int   tests_run    = 0;
  int   tests_failed = 0;
  int   cyc          = 0;
  int   pop_cycles[$];
  exp_t main_q[$];
  logic [W-1:0] last_result;
  logic sweep_start;

  MulCode      vec_op  [4] = '{MUL, MULH, MULHU, MULHSU};
  logic [31:0] vec_a   [4] = '{32'h12345678, 32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFFF};
  logic [31:0] vec_b   [4] = '{32'h00000010, 32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFFF};
  logic [31:0] vec_exp [4] = '{32'h23456780, 32'h40000000, 32'hFFFFFFFE, 32'hFFFFFFFF};

  pipelined_multiplier #(.WIDTH(W), .STAGES(S), .TAG_WIDTH(TW)) dut (
    .clk        (clk),
    .rst        (rst),
    .flush      (flush),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_op      (in_op),
    .in_op1     (in_op1),
    .in_op2     (in_op2),
    .in_tag     (in_tag),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_tag    (out_tag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Treat operands as mathematical integers, multiply, then pick the requested W-bit half.
  function automatic logic [63:0] refMul(input int w, input MulCode op, input logic [63:0] a, input logic [63:0] b);
    logic [63:0]         mask;
    logic [63:0]         am;
    logic [63:0]         bm;
    logic signed [131:0] va;
    logic signed [131:0] vb;
    logic signed [131:0] prod;
    mask = (w == 64) ? {64{1'b1}} : ((64'd1 << w) - 64'd1);
    am   = a & mask;
    bm   = b & mask;
    va   = 132'(am);
    vb   = 132'(bm);
    if (op != MULHU && am[w-1]) va = va - (132'sd1 <<< w);
    if ((op == MUL || op == MULH) && bm[w-1]) vb = vb - (132'sd1 <<< w);
    prod = va * vb;
    if (op == MUL) return 64'(prod) & mask;
    return 64'(prod >>> w) & mask;
  endfunction

  function automatic logic [63:0] pickOperand(input int w);
    logic [63:0] mask;
    logic [63:0] r;
    mask = (w == 64) ? {64{1'b1}} : ((64'd1 << w) - 64'd1);
    case ($urandom_range(0, 7))
      0:       r = 64'd0;
      1:       r = 64'd1;
      2:       r = mask;
      3:       r = 64'd1 << (w - 1);
      4:       r = mask >> 1;
      default: r = {$urandom, $urandom};
    endcase
    return r & mask;
  endfunction

  function automatic MulCode randOp();
    return MulCode'($urandom_range(0, 3));
  endfunction

  // One cycle on the 32/3 instance: drive at negedge, then score any handshakes due at the next posedge.
  task automatic applyStimulus(input logic v, input MulCode op, input logic [W-1:0] a, input logic [W-1:0] b,
                               input logic [TW-1:0] tag, input logic ordy, input logic fl);
    exp_t e;
    @(negedge clk);
    cyc++;
    in_valid  = v;
    in_op     = op;
    in_op1    = a;
    in_op2    = b;
    in_tag    = tag;
    out_ready = ordy;
    flush     = fl;
    #1;
    if (out_valid && out_ready) begin
      pop_cycles.push_back(cyc);
      last_result = out_result;
      if (main_q.size() == 0) begin
        checkOutput("spurious_output_tag", 64'(out_tag), 64'hFFFF_FFFF);
      end else begin
        e = main_q.pop_front();
        checkOutput("result", 64'(out_result), e.res);
        checkOutput("tag", 64'(out_tag), 64'(e.tag));
      end
    end
    if (fl) begin
      main_q.delete();
    end else if (in_valid && in_ready) begin
      e.res = refMul(W, op, 64'(a), 64'(b));
      e.tag = tag;
      main_q.push_back(e);
    end
  endtask

  task automatic idleCycles(input int n, input logic ordy);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, MUL, '0, '0, '0, ordy, 1'b0);
  endtask

  for (genvar g = 0; g < 2; g++) begin : sweep
    localparam int SW = (g == 0) ? 8 : 64;
    localparam int SS = (g == 0) ? 1 : 6;

    logic          done;
    logic          s_flush;
    logic          s_in_valid;
    logic          s_in_ready;
    MulCode        s_in_op;
    logic [SW-1:0] s_in_op1;
    logic [SW-1:0] s_in_op2;
    logic [TW-1:0] s_in_tag;
    logic          s_out_valid;
    logic          s_out_ready;
    logic [SW-1:0] s_out_result;
    logic [TW-1:0] s_out_tag;
    exp_t          s_q[$];

    pipelined_multiplier #(.WIDTH(SW), .STAGES(SS), .TAG_WIDTH(TW)) u_dut (
      .clk        (clk),
      .rst        (rst),
      .flush      (s_flush),
      .in_valid   (s_in_valid),
      .in_ready   (s_in_ready),
      .in_op      (s_in_op),
      .in_op1     (s_in_op1),
      .in_op2     (s_in_op2),
      .in_tag     (s_in_tag),
      .out_valid  (s_out_valid),
      .out_ready  (s_out_ready),
      .out_result (s_out_result),
      .out_tag    (s_out_tag)
    );

    initial begin
      exp_t e;
      done        = 1'b0;
      s_flush     = 1'b0;
      s_in_valid  = 1'b0;
      s_in_op     = MUL;
      s_in_op1    = '0;
      s_in_op2    = '0;
      s_in_tag    = '0;
      s_out_ready = 1'b1;
      wait (sweep_start);
      for (int c = 0; c < 400; c++) begin
        @(negedge clk);
        s_in_valid  = (c < 380) && ($urandom_range(0, 3) != 0);
        s_in_op     = randOp();
        s_in_op1    = SW'(pickOperand(SW));
        s_in_op2    = SW'(pickOperand(SW));
        s_in_tag    = TW'(c);
        s_out_ready = (c >= 380) || ($urandom_range(0, 3) != 0);
        #1;
        if (s_out_valid && s_out_ready) begin
          if (s_q.size() == 0) begin
            checkOutput($sformatf("w%0d_spurious_tag", SW), 64'(s_out_tag), 64'hFFFF_FFFF);
          end else begin
            e = s_q.pop_front();
            checkOutput($sformatf("w%0d_result", SW), 64'(s_out_result), e.res);
            checkOutput($sformatf("w%0d_tag", SW), 64'(s_out_tag), 64'(e.tag));
          end
        end
        if (s_in_valid && s_in_ready) begin
          e.res = refMul(SW, s_in_op, 64'(s_in_op1), 64'(s_in_op2));
          e.tag = s_in_tag;
          s_q.push_back(e);
        end
      end
      checkOutput($sformatf("w%0d_drained", SW), 64'(s_q.size()), 64'd0);
      done = 1'b1;
    end
  end

  initial begin
    int start;
    int lat;

    rst         = 1'b1;
    flush       = 1'b0;
    in_valid    = 1'b0;
    in_op       = MUL;
    in_op1      = '0;
    in_op2      = '0;
    in_tag      = '0;
    out_ready   = 1'b1;
    sweep_start = 1'b0;
    last_result = '0;

    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    checkOutput("reset_out_valid", 64'(out_valid), 64'd0);
    checkOutput("reset_out_result", 64'(out_result), 64'd0);
    checkOutput("reset_out_tag", 64'(out_tag), 64'd0);
    checkOutput("reset_in_ready", 64'(in_ready), 64'd1);

    for (int i = 0; i < 4; i++) begin
      pop_cycles.delete();
      start = cyc + 1;
      applyStimulus(1'b1, vec_op[i], vec_a[i], vec_b[i], TW'(i + 1), 1'b1, 1'b0);
      idleCycles(5, 1'b1);
      lat = (pop_cycles.size() > 0) ? pop_cycles[0] - start : -1;
      checkOutput($sformatf("vec%0d_count", i), 64'(pop_cycles.size()), 64'd1);
      checkOutput($sformatf("vec%0d_latency", i), 64'(lat), 64'(S));
      checkOutput($sformatf("vec%0d_result", i), 64'(last_result), 64'(vec_exp[i]));
    end

    pop_cycles.delete();
    start = cyc + 1;
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1'b1, randOp(), W'(pickOperand(W)), W'(pickOperand(W)), TW'(i), 1'b1, 1'b0);
      checkOutput($sformatf("stream_in_ready%0d", i), 64'(in_ready), 64'd1);
    end
    idleCycles(6, 1'b1);
    checkOutput("stream_count", 64'(pop_cycles.size()), 64'd8);
    for (int k = 0; k < 8; k++) begin
      lat = (pop_cycles.size() > k) ? pop_cycles[k] : -1;
      checkOutput($sformatf("stream_slot%0d", k), 64'(lat), 64'(start + S + k));
    end

    pop_cycles.delete();
    for (int i = 0; i < 3; i++)
      applyStimulus(1'b1, randOp(), W'(pickOperand(W)), W'(pickOperand(W)), TW'(16 + i), 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, randOp(), W'(pickOperand(W)), W'(pickOperand(W)), TW'(24 + i), 1'b0, 1'b0);
      checkOutput("stall_in_ready", 64'(in_ready), 64'd0);
      checkOutput("stall_out_valid", 64'(out_valid), 64'd1);
      checkOutput("stall_result_held", 64'(out_result), main_q[0].res);
      checkOutput("stall_tag_held", 64'(out_tag), 64'(main_q[0].tag));
    end
    for (int i = 0; i < 3; i++)
      applyStimulus(1'b1, randOp(), W'(pickOperand(W)), W'(pickOperand(W)), TW'(19 + i), 1'b1, 1'b0);
    idleCycles(6, 1'b1);
    checkOutput("stall_delivered", 64'(pop_cycles.size()), 64'd6);
    checkOutput("stall_queue_empty", 64'(main_q.size()), 64'd0);

    pop_cycles.delete();
    for (int i = 0; i < 3; i++)
      applyStimulus(1'b1, randOp(), W'(pickOperand(W)), W'(pickOperand(W)), TW'(32 + i), 1'b1, 1'b0);
    applyStimulus(1'b1, MUL, 32'd7, 32'd9, TW'(35), 1'b1, 1'b1);
    start = cyc + 1;
    applyStimulus(1'b1, MULHU, 32'hDEADBEEF, 32'h12345678, TW'(40), 1'b1, 1'b0);
    checkOutput("post_flush_out_valid", 64'(out_valid), 64'd0);
    checkOutput("post_flush_in_ready", 64'(in_ready), 64'd1);
    idleCycles(6, 1'b1);
    checkOutput("flush_count", 64'(pop_cycles.size()), 64'd2);
    lat = (pop_cycles.size() > 1) ? pop_cycles[1] - start : -1;
    checkOutput("flush_reissue_latency", 64'(lat), 64'(S));
    checkOutput("flush_reissue_result", 64'(last_result), refMul(W, MULHU, 64'h0DEADBEEF, 64'h012345678));

    for (int i = 0; i < 3; i++)
      applyStimulus(1'b1, randOp(), W'(pickOperand(W)), W'(pickOperand(W)), TW'(48 + i), 1'b1, 1'b0);
    @(negedge clk);
    rst       = 1'b1;
    out_ready = 1'b0;
    in_valid  = 1'b1;
    @(negedge clk);
    rst      = 1'b0;
    in_valid = 1'b0;
    main_q.delete();
    #1;
    checkOutput("midreset_out_valid", 64'(out_valid), 64'd0);
    checkOutput("midreset_out_result", 64'(out_result), 64'd0);
    checkOutput("midreset_out_tag", 64'(out_tag), 64'd0);
    checkOutput("midreset_in_ready", 64'(in_ready), 64'd1);

    for (int i = 0; i < 300; i++) begin
      applyStimulus($urandom_range(0, 3) != 0, randOp(), W'(pickOperand(W)), W'(pickOperand(W)),
                    TW'($urandom), $urandom_range(0, 3) != 0, $urandom_range(0, 31) == 0);
    end
    idleCycles(10, 1'b1);
    checkOutput("random_drained", 64'(main_q.size()), 64'd0);

    sweep_start = 1'b1;
    for (int i = 0; i < 2000 && !(sweep[0].done && sweep[1].done); i++) @(negedge clk);
    checkOutput("sweep8_finished", 64'(sweep[0].done), 64'd1);
    checkOutput("sweep64_finished", 64'(sweep[1].done), 64'd1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/pipelined_multiplier.md
# pipelined_multiplier

Parametrised, fully pipelined integer multiplier for the MUL/DIV execution lane. It accepts one RISC-V M-extension multiply (MUL, MULH, MULHSU, MULHU) per cycle over a valid/ready handshake, returns the selected WIDTH-bit half of the product after a fixed STAGES-cycle latency, and carries an opaque tag alongside each operation. Backpressure stalls the whole pipeline, and a flush input squashes all in-flight operations on a misprediction or exception.

## Interface
- WIDTH, 32: operand and result width in bits; legal values are 8 to 64.
- STAGES, 3: latency in cycles from input handshake to out_valid; legal values are 1 to 6.
- TAG_WIDTH, 6: width of the tag that is passed through unchanged.
- clk  in  1  clock; the only clock, and the block is single-clock.
- rst  in  1  reset; synchronous and active-high.
- flush  in  1  squashes every in-flight operation.
- in_valid  in  1  an operation is presented on the input.
- in_ready  out  1  the block can accept an operation this cycle.
- in_op  in  MulCode  selects MUL, MULH, MULHSU or MULHU.
- in_op1  in  WIDTH  rs1 operand.
- in_op2  in  WIDTH  rs2 operand.
- in_tag  in  TAG_WIDTH  tag for the operation.
- out_valid  out  1  a result is presented on the output.
- out_ready  in  1  the consumer accepts the result.
- out_result  out  WIDTH  selected half of the product.
- out_tag  out  TAG_WIDTH  tag of the result.

## Operation
- Operand sign selection by op:
  - MUL: both operands signed.
  - MULH: both operands signed.
  - MULHSU: op1 signed, op2 unsigned.
  - MULHU: both operands unsigned.
- Each operand is extended to WIDTH+1 bits: sign bit replicated if signed, zero if unsigned.
- The two extended operands form a signed product of 2·WIDTH+2 bits.
- Result selection:
  - MUL returns product[WIDTH-1:0].
  - All other ops return product[2·WIDTH-1:WIDTH].
- The op, or a decoded high/low select bit, travels down the pipeline with the data.
- Pipeline structure:
  - Stage 0 registers the extended operands, the select bit and the tag.
  - The multiply is followed by STAGES-1 register slices, so synthesis can retime across DSP registers.
  - For STAGES=1, the product is computed combinationally from the inputs into the single output register.
- Each stage holds a valid bit plus its payload. Payload registers load only when the stage advances.
- An input handshake occurs when in_valid && in_ready.
- An output handshake occurs when out_valid && out_ready.
- The pipeline uses a global stall: advance = !(out_valid && !out_ready).
  - While advance=0, every stage holds its contents.
  - in_ready = advance.
- Bubbles are not compressed. A stalled pipeline holds its bubbles as well as its valid entries.
- Flush clears every valid bit on the next edge. Payload contents are don't-care after a flush.
- If flush and an input handshake occur in the same cycle, flush wins and the input operation is discarded.
- If flush and an output handshake occur in the same cycle, the consumer's acceptance stands and the result is treated as delivered.
- Reset clears all valid bits, out_result and out_tag.
- Reset asserted mid-operation behaves identically to flush, and additionally zeroes the payload registers.

## Timing
- Reset values: out_valid=0, out_result=0, out_tag=0. in_ready=1 from the first cycle after rst deasserts.
- Latency: an operation accepted at edge N is presented with out_valid=1 after edge N+STAGES-1, i.e. it is visible during the cycle following STAGES edges, provided there is no stall.
- Throughput is one operation per cycle with out_ready held high.
- Stall response is zero-cycle: out_ready low in cycle C forces in_ready low in cycle C. This is a combinational path from out_ready to in_ready.
- out_result and out_tag remain stable while out_valid=1 and out_ready=0.
- The first cycle after flush shows out_valid=0 and in_ready=1.

## Structure
- The MulDivTypes package holds:
  - typedef enum MulCode {MUL, MULH, MULHSU, MULHU}.
  - A helper function mulOp1Signed(MulCode).
  - A helper function mulOp2Signed(MulCode).
  - A helper function mulSelectHigh(MulCode).
- Parameter-dependent widths are derived locally from WIDTH and are not added to the package.
- One sub-module, operand_sign_extender, parametrised on WIDTH, is instanced once per operand.
- The pipeline registers are implemented as a generate loop over an array of per-stage structs.

## Test plan
- Functional results at WIDTH=32, STAGES=3:
  - MUL 0x12345678×0x00000010 → 0x23456780.
  - MULH 0x80000000×0x80000000 → 0x40000000.
  - MULHU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFE.
  - MULHSU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFF.
- Streaming: 8 back-to-back ops with tags 0..7 and out_ready=1. The first out_valid appears 3 edges after the first accept, tags emerge in order with no gaps, and in_ready stays 1 throughout.
- Backpressure: drop out_ready for 4 cycles with the pipeline full.
  - in_ready=0 in the same cycles.
  - out_result and out_tag are held stable.
  - Raising out_ready resumes delivery with no loss or duplication.
- Flush: assert flush with 3 ops in flight plus a simultaneous in_valid. No outputs appear afterwards, and an op issued the following cycle returns correctly after 3 edges.
- Reset mid-stream: assert rst with the pipeline full and out_ready=0. Next cycle out_valid=0, out_result=0, out_tag=0, and in_ready=1.
- Parameter sweep: WIDTH=8 with STAGES=1, and WIDTH=64 with STAGES=6. Random ops are checked against a reference model covering the corner cases 0, 1, −1, MIN and MAX.
